instr_mem_loader: RTL

Parametrised instruction memory with a built-in streaming program loader for the jacaranda-8 core.
- The CPU fetch port reads asynchronously by default; a registered read is available by parameter.
- A valid/ready byte stream writes a program into sequential addresses starting at a programmable base address.
- The block tracks the session byte count, signals completion and flags address wrap-around.
- It sits between the core's fetch path and an external loader (UART or Wishbone bridge).

---
 rtl/instr_mem_loader.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/instr_mem_loader.sv
// Instruction memory for the jacaranda-8 core with a streaming program loader.
// The fetch port reads combinationally (READ_REG=0) or with one cycle of
// latency (READ_REG=1); a valid/ready byte stream fills sequential addresses
// starting at a programmable base, tracking count, completion and wrap.
module instr_mem_loader #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int READ_REG = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] r_data,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              loading,
    output logic              load_done,
    output logic [ADDR_W:0]   load_count,
    output logic              load_ovf
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t            state;
    logic              loading_q;
    logic              done_q;
    logic              ovf_q;
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W:0]   count_q;
    logic              accept;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    // A restart request takes priority over a word offered in the same cycle.
    assign load_ready = loading_q && !load_start;
    assign accept     = (state == LOAD) && !load_start && load_valid;

    assign loading    = loading_q;
    assign load_done  = done_q;
    assign load_count = count_q;
    assign load_ovf   = ovf_q;

    // Loader FSM: session control, write pointer, count and wrap flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            loading_q <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            wptr      <= '0;
            count_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state     <= LOAD;
                        loading_q <= 1'b1;
                        wptr      <= load_base;
                        count_q   <= '0;
                        ovf_q     <= 1'b0;
                    end
                end
                LOAD: begin
                    if (load_start) begin
                        wptr    <= load_base;
                        count_q <= '0;
                        ovf_q   <= 1'b0;
                    end else if (accept) begin
                        wptr <= wptr + ADDR_W'(1);
                        if (count_q != COUNT_MAX) begin
                            count_q <= count_q + (ADDR_W + 1)'(1);
                        end
                        if ((wptr == '1) && !load_last) begin
                            ovf_q <= 1'b1;
                        end
                        if (load_last) begin
                            state     <= DONE;
                            loading_q <= 1'b0;
                            done_q    <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (load_start) begin
                        state     <= LOAD;
                        loading_q <= 1'b1;
                        wptr      <= load_base;
                        count_q   <= '0;
                        ovf_q     <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    loading_q <= 1'b0;
                end
            endcase
        end
    end

    // Memory write port, driven only by accepted loader words; no reset so
    // program contents survive a reset.
    always_ff @(posedge clock) begin
        if (!reset && accept) begin
            mem[wptr] <= load_data;
        end
    end

    generate
        if (READ_REG != 0) begin : g_read_reg
            logic [DATA_W-1:0] rd_q;

            // Registered fetch; the output gate hides it while loading so the
            // edge that leaves LOAD still delivers real memory content.
            always_ff @(posedge clock) begin
                if (reset) begin
                    rd_q <= '0;
                end else begin
                    rd_q <= mem[addr];
                end
            end

            assign r_data = (reset || loading_q) ? '0 : rd_q;
        end else begin : g_read_comb
            assign r_data = (reset || loading_q) ? '0 : mem[addr];
        end
    endgenerate

endmodule
